// File: rtl/regfile_sb.sv
// Parametrised 2R1W integer register file with optional write-to-read bypass,
// a per-register busy scoreboard for RAW hazard detection and a debug read port.
module regfile_sb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              r1_busy,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              r2_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int   NREG   = 2 ** ADDR_W;
    localparam int   CNT_W  = ADDR_W + 1;
    localparam logic BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic wr_en_s;
    logic iss_en_s;
    logic inc_s;
    logic dec_s;
    logic byp1_s;
    logic byp2_s;

    // Writes and issues to x0 are dropped at the source so x0 is never busy or counted.
    assign wr_en_s  = we && (waddr != '0);
    assign iss_en_s = issue_valid && (issue_rd != '0);

    // Register array: cleared on reset, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Next busy vector: set has priority over clear on the same index.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (iss_en_s && (issue_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_en_s && (waddr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
        busy_d[0] = 1'b0;
    end

    // Counter deltas track exactly the 0->1 and 1->0 transitions of busy bits.
    always_comb begin
        inc_s = iss_en_s && !busy_q[issue_rd];
        dec_s = wr_en_s && busy_q[waddr] && !(iss_en_s && (issue_rd == waddr));
        if (inc_s && !dec_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_s && !inc_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Scoreboard and pending counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: x0 returns zero, a matching same-cycle write is forwarded when enabled.
    always_comb begin
        byp1_s = BYP_EN && wr_en_s && (waddr == raddr1);
        byp2_s = BYP_EN && wr_en_s && (waddr == raddr2);

        if (raddr1 == '0) begin
            rdata1  = '0;
            r1_busy = 1'b0;
        end else if (byp1_s) begin
            rdata1  = wdata;
            r1_busy = 1'b0;
        end else begin
            rdata1  = regs_q[raddr1];
            r1_busy = busy_q[raddr1];
        end

        if (raddr2 == '0) begin
            rdata2  = '0;
            r2_busy = 1'b0;
        end else if (byp2_s) begin
            rdata2  = wdata;
            r2_busy = 1'b0;
        end else begin
            rdata2  = regs_q[raddr2];
            r2_busy = busy_q[raddr2];
        end

        if (dbg_addr == '0) begin
            dbg_data = '0;
        end else begin
            dbg_data = regs_q[dbg_addr];
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb: one bypassing instance and one
// non-bypassing instance share the same stimulus.
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] raddr1, raddr2, waddr, issue_rd, dbg_addr;
    logic [DW-1:0] wdata;
    logic          we, issue_valid;

    logic [DW-1:0] rdata1, rdata2, dbg_data;
    logic          r1_busy, r2_busy;
    logic [AW:0]   pending_cnt;

    logic [DW-1:0] nb_rdata1, nb_rdata2, nb_dbg_data;
    logic          nb_r1_busy, nb_r2_busy;
    logic [AW:0]   nb_pending_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.ADDR_W(AW), .DATA_W(DW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .rdata1(rdata1), .r1_busy(r1_busy),
        .raddr2(raddr2), .rdata2(rdata2), .r2_busy(r2_busy),
        .we(we), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pending_cnt(pending_cnt)
    );

    regfile_sb #(.ADDR_W(AW), .DATA_W(DW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .rdata1(nb_rdata1), .r1_busy(nb_r1_busy),
        .raddr2(raddr2), .rdata2(nb_rdata2), .r2_busy(nb_r2_busy),
        .we(we), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data), .pending_cnt(nb_pending_cnt)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          iv;
        logic [AW-1:0] ird;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [AW-1:0] dbg;
        logic [DW-1:0] e_rd1;
        logic          e_b1;
        logic [DW-1:0] e_rd2;
        logic          e_b2;
        logic [DW-1:0] e_dbg;
        logic [AW:0]   e_cnt;
        logic [DW-1:0] e_rd1_nb;
        logic          e_b1_nb;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mkv(
        input logic we_v, input int wa, input logic [DW-1:0] wd,
        input logic iv, input int ird,
        input int ra1, input int ra2, input int dbg,
        input logic [DW-1:0] e_rd1, input logic e_b1,
        input logic [DW-1:0] e_rd2, input logic e_b2,
        input logic [DW-1:0] e_dbg, input int e_cnt,
        input logic [DW-1:0] e_rd1_nb, input logic e_b1_nb);
        vec_t v;
        v.we = we_v;  v.waddr = AW'(wa);  v.wdata = wd;
        v.iv = iv;    v.ird = AW'(ird);
        v.ra1 = AW'(ra1); v.ra2 = AW'(ra2); v.dbg = AW'(dbg);
        v.e_rd1 = e_rd1; v.e_b1 = e_b1; v.e_rd2 = e_rd2; v.e_b2 = e_b2;
        v.e_dbg = e_dbg; v.e_cnt = (AW+1)'(e_cnt);
        v.e_rd1_nb = e_rd1_nb; v.e_b1_nb = e_b1_nb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we_v, input int wa, input logic [DW-1:0] wd,
                         input logic iv, input int ird,
                         input int ra1, input int ra2, input int dbg);
        we = we_v; waddr = AW'(wa); wdata = wd;
        issue_valid = iv; issue_rd = AW'(ird);
        raddr1 = AW'(ra1); raddr2 = AW'(ra2); dbg_addr = AW'(dbg);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we wa wdata iv ird ra1 ra2 dbg | rd1 b1 rd2 b2 dbg cnt | rd1_nb b1_nb
        vecs[0]  = mkv(0, 0, 32'h0,        0, 0, 31, 1, 16, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[1]  = mkv(1, 5, 32'hDEADBEEF, 0, 0,  0, 0,  5, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[2]  = mkv(1, 0, 32'h00001234, 0, 0,  5, 0,  5, 32'hDEADBEEF, 0, 32'h0,        0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        vecs[3]  = mkv(1, 7, 32'h11111111, 0, 0,  5, 0,  0, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 32'hDEADBEEF, 0);
        vecs[4]  = mkv(1, 7, 32'hA5A5A5A5, 0, 0,  7, 7,  7, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'h11111111, 0, 32'h11111111, 0);
        vecs[5]  = mkv(0, 0, 32'h0,        0, 0,  7, 7,  7, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0);
        vecs[6]  = mkv(0, 0, 32'h0,        1, 3,  3, 0,  0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[7]  = mkv(0, 0, 32'h0,        0, 0,  3, 3,  0, 32'h0,        1, 32'h0,        1, 32'h0,        1, 32'h0,        1);
        vecs[8]  = mkv(1, 3, 32'h00000033, 0, 0,  3, 0,  3, 32'h00000033, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1);
        vecs[9]  = mkv(0, 0, 32'h0,        0, 0,  3, 0,  3, 32'h00000033, 0, 32'h0,        0, 32'h00000033, 0, 32'h00000033, 0);
        vecs[10] = mkv(0, 0, 32'h0,        1, 4,  4, 0,  0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[11] = mkv(1, 4, 32'h00000044, 1, 4,  4, 0,  0, 32'h00000044, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1);
        vecs[12] = mkv(0, 0, 32'h0,        0, 0,  4, 4,  4, 32'h00000044, 1, 32'h00000044, 1, 32'h00000044, 1, 32'h00000044, 1);
        vecs[13] = mkv(1, 4, 32'h00000045, 1, 8,  8, 4,  0, 32'h0,        0, 32'h00000045, 0, 32'h0,        1, 32'h0,        0);
        vecs[14] = mkv(0, 0, 32'h0,        0, 0,  8, 4,  4, 32'h0,        1, 32'h00000045, 0, 32'h00000045, 1, 32'h0,        1);

        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, int'(vecs[i].waddr), vecs[i].wdata, vecs[i].iv,
                  int'(vecs[i].ird), int'(vecs[i].ra1), int'(vecs[i].ra2), int'(vecs[i].dbg));
            @(negedge clk);
            chk($sformatf("v%0d.rdata1", i),    64'(rdata1),      64'(vecs[i].e_rd1));
            chk($sformatf("v%0d.r1_busy", i),   64'(r1_busy),     64'(vecs[i].e_b1));
            chk($sformatf("v%0d.rdata2", i),    64'(rdata2),      64'(vecs[i].e_rd2));
            chk($sformatf("v%0d.r2_busy", i),   64'(r2_busy),     64'(vecs[i].e_b2));
            chk($sformatf("v%0d.dbg_data", i),  64'(dbg_data),    64'(vecs[i].e_dbg));
            chk($sformatf("v%0d.pending", i),   64'(pending_cnt), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d.nb_rdata1", i), 64'(nb_rdata1),   64'(vecs[i].e_rd1_nb));
            chk($sformatf("v%0d.nb_r1_busy", i), 64'(nb_r1_busy), 64'(vecs[i].e_b1_nb));
            step();
        end

        // Build up x8 (already busy), x1, x2, x9 busy; x9 written while not busy.
        drive(1, 9, 32'h00000055, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("wr_nonbusy.pending", 64'(pending_cnt), 64'd1);
        step();
        drive(0, 0, 32'h0, 1, 2, 0, 0, 0);
        step();
        drive(0, 0, 32'h0, 1, 9, 0, 0, 0);
        step();
        drive(0, 0, 32'h0, 0, 0, 9, 1, 9);
        @(negedge clk);
        chk("pre_rst.r1_busy", 64'(r1_busy), 64'd1);
        chk("pre_rst.r2_busy", 64'(r2_busy), 64'd1);
        chk("pre_rst.dbg9",    64'(dbg_data), 64'h55);
        chk("pre_rst.pending", 64'(pending_cnt), 64'd4);
        chk("pre_rst.nb_pending", 64'(nb_pending_cnt), 64'd4);
        step();

        // Reset wins over a simultaneous writeback and issue.
        rst = 1'b1;
        drive(1, 9, 32'h00000099, 1, 10, 0, 0, 0);
        step();
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 9, 8, 9);
        @(negedge clk);
        chk("post_rst.rdata1",  64'(rdata1), 64'h0);
        chk("post_rst.r1_busy", 64'(r1_busy), 64'd0);
        chk("post_rst.r2_busy", 64'(r2_busy), 64'd0);
        chk("post_rst.dbg9",    64'(dbg_data), 64'h0);
        chk("post_rst.pending", 64'(pending_cnt), 64'd0);
        chk("post_rst.nb_pending", 64'(nb_pending_cnt), 64'd0);
        step();
        drive(0, 0, 32'h0, 0, 0, 10, 5, 7);
        @(negedge clk);
        chk("post_rst.r1_busy10", 64'(r1_busy), 64'd0);
        chk("post_rst.rdata2_x5", 64'(rdata2), 64'h0);
        chk("post_rst.dbg7",      64'(dbg_data), 64'h0);
        chk("post_rst.pending2",  64'(pending_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
